// File: rtl/icache_line_fetcher_if.sv
// Core-fetch and ROM-refill signal bundle for the instruction cache.
// The master side is the environment (core + ROM); the cache connects as slave.
interface icache_line_fetcher_if #(
    parameter int CACHE_WORD_ADR_SIZE = 2,
    parameter int CNT_W               = 32
);
    localparam int LINE_WORDS = 2 ** CACHE_WORD_ADR_SIZE;

    logic                         fetch_req;
    logic [31:0]                  fetch_addr;
    logic                         flush;
    logic [31:0]                  inst;
    logic                         inst_valid;
    logic                         stall;
    logic [31:0]                  rom_addr;
    logic                         rom_re;
    logic [LINE_WORDS-1:0][31:0]  rom_out;
    logic                         rom_oe;
    logic [CNT_W-1:0]             hit_cnt;
    logic [CNT_W-1:0]             miss_cnt;

    modport master (
        output fetch_req, fetch_addr, flush, rom_out, rom_oe,
        input  inst, inst_valid, stall, rom_addr, rom_re, hit_cnt, miss_cnt
    );

    modport slave (
        input  fetch_req, fetch_addr, flush, rom_out, rom_oe,
        output inst, inst_valid, stall, rom_addr, rom_re, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_line_fetcher.sv
// Direct-mapped instruction cache: zero-latency hit lookup, whole-line refill from
// a line-wide ROM port, fence.i flush, and saturating hit/miss counters.
module icache_line_fetcher #(
    parameter int CACHE_WORD_ADR_SIZE = 2,
    parameter int INDEX_BITS          = 4,
    parameter int CNT_W               = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_line_fetcher_if.slave   bus
);
    localparam int W          = CACHE_WORD_ADR_SIZE;
    localparam int I          = INDEX_BITS;
    localparam int LINES      = 2 ** I;
    localparam int LINE_WORDS = 2 ** W;
    localparam int TAG_W      = 32 - 2 - W - I;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [LINES-1:0]                       valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]            tag_q, tag_d;
    logic [LINES-1:0][LINE_WORDS-1:0][31:0] data_q, data_d;
    logic [31:0]                            rom_addr_q, rom_addr_d;
    logic                                   flush_seen_q, flush_seen_d;
    logic [CNT_W-1:0]                       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                       miss_cnt_q, miss_cnt_d;

    logic [W-1:0]     word_sel;
    logic [I-1:0]     idx;
    logic [I-1:0]     fill_idx;
    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             start_miss;
    logic             install;
    logic [1:0]       unused_addr_lsb;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign word_sel        = bus.fetch_addr[2 +: W];
    assign idx             = bus.fetch_addr[2 + W +: I];
    assign tag_in          = bus.fetch_addr[31 -: TAG_W];
    assign unused_addr_lsb = bus.fetch_addr[1:0];

    // The refill target is recovered from the latched line address, so later
    // fetch_addr changes cannot redirect an in-flight refill.
    assign fill_idx = rom_addr_q[2 + W +: I];
    assign fill_tag = rom_addr_q[31 -: TAG_W];

    // A flush in the same cycle suppresses the hit so the core retries after invalidation.
    assign hit        = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag_in) && !bus.flush;
    assign start_miss = (state_q == IDLE) && bus.fetch_req && !hit && !bus.flush;
    assign install    = (state_q == REQ) && bus.rom_oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_miss) state_d = REQ;
            REQ:     if (bus.rom_oe) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.rom_re     = (state_q == REQ);
        bus.inst_valid = bus.fetch_req && hit;
        bus.stall      = (bus.fetch_req && !hit) || (state_q != IDLE);
        bus.inst       = '0;
        if (bus.fetch_req && hit) begin
            bus.inst = data_q[idx][word_sel];
        end
    end

    always_comb begin
        rom_addr_d   = rom_addr_q;
        flush_seen_d = flush_seen_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (start_miss) begin
            rom_addr_d   = {bus.fetch_addr[31:2 + W], {(2 + W){1'b0}}};
            flush_seen_d = 1'b0;
            miss_cnt_d   = sat_inc(miss_cnt_q);
        end else if (state_q == REQ && bus.flush) begin
            flush_seen_d = 1'b1;
        end

        // The line is always written; only the valid bit decides whether it is usable.
        if (install) begin
            tag_d[fill_idx]  = fill_tag;
            data_d[fill_idx] = bus.rom_out;
            if (!flush_seen_q && !bus.flush) begin
                valid_d[fill_idx] = 1'b1;
            end
        end

        if (bus.flush) begin
            valid_d = '0;
        end

        if (bus.fetch_req && hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            rom_addr_q   <= '0;
            flush_seen_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            rom_addr_q   <= rom_addr_d;
            flush_seen_q <= flush_seen_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_icache_line_fetcher.sv
// Directed bench for icache_line_fetcher with a line-level cache model checked
// every falling edge, plus literal expectations along the scripted scenarios.
module tb_icache_line_fetcher;
    localparam int W  = 2;
    localparam int I  = 4;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    icache_line_fetcher_if #(.CACHE_WORD_ADR_SIZE(W), .CNT_W(CW)) bus ();

    icache_line_fetcher #(
        .CACHE_WORD_ADR_SIZE(W),
        .INDEX_BITS(I),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: each of the 16 slots remembers which line address it holds.
    bit          m_valid [16];
    logic [31:0] m_line  [16];
    logic [31:0] m_data  [16][4];
    bit          m_pend, m_bubble, m_dirty;
    logic [31:0] m_addr;
    int          m_hits, m_miss;
    int          m_ix, m_wd;
    bit          m_idle, m_hit;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        m_pend = 0; m_bubble = 0; m_dirty = 0; m_addr = '0; m_hits = 0; m_miss = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (reset) model_reset();
        if (chk_en) begin
            m_ix   = int'((bus.fetch_addr >> 4) & 32'hF);
            m_wd   = int'((bus.fetch_addr >> 2) & 32'h3);
            m_idle = !m_pend && !m_bubble;
            m_hit  = m_idle && m_valid[m_ix] && (m_line[m_ix] == (bus.fetch_addr >> 4)) && !bus.flush;
            check("m_inst_valid", bus.inst_valid, bus.fetch_req && m_hit);
            check("m_stall", bus.stall, (bus.fetch_req && !m_hit) || !m_idle);
            check("m_inst", bus.inst, (bus.fetch_req && m_hit) ? m_data[m_ix][m_wd] : 32'h0);
            check("m_rom_re", bus.rom_re, m_pend);
            check("m_rom_addr", bus.rom_addr, m_addr);
            check("m_hit_cnt", bus.hit_cnt, (m_hits > 15) ? 15 : m_hits);
            check("m_miss_cnt", bus.miss_cnt, (m_miss > 15) ? 15 : m_miss);
            if (!reset) begin
                if (m_pend) begin
                    if (bus.flush) m_dirty = 1;
                    if (bus.rom_oe) begin
                        if (!m_dirty) begin
                            m_valid[m_addr[7:4]] = 1'b1;
                            m_line[m_addr[7:4]]  = m_addr >> 4;
                            for (int k = 0; k < 4; k++) m_data[m_addr[7:4]][k] = bus.rom_out[k];
                        end
                        m_pend = 0; m_bubble = 1;
                    end
                end else if (m_bubble) begin
                    m_bubble = 0;
                end else if (bus.fetch_req && !m_hit && !bus.flush) begin
                    m_pend = 1; m_dirty = 0; m_addr = bus.fetch_addr & ~32'hF; m_miss++;
                end
                if (bus.flush) for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
                if (bus.fetch_req && m_hit) m_hits++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for rom_re, then returns the line on the lat-th REQ cycle; ends in FILL.
    task automatic serve(input int lat, input logic [3:0][31:0] line);
        int n = 0;
        while (!bus.rom_re && n < 20) begin
            tick();
            n++;
        end
        check("serve_rom_re_seen", bus.rom_re, 1);
        repeat (lat - 1) tick();
        bus.rom_out = line;
        bus.rom_oe  = 1'b1;
        tick();
        bus.rom_oe  = 1'b0;
    endtask

    localparam logic [3:0][31:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [3:0][31:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [3:0][31:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [3:0][31:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.flush      = 1'b0;
        bus.rom_oe     = 1'b0;
        bus.rom_out    = '0;
        repeat (2) tick();
        chk_en = 1'b1;

        // Reset state
        check("rst_rom_re", bus.rom_re, 0);
        check("rst_rom_addr", bus.rom_addr, 32'h0);
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_miss_cnt", bus.miss_cnt, 0);
        check("rst_stall", bus.stall, 0);
        reset = 1'b0;

        // Scenario 1: cold miss on 0x0
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
        #1;
        check("s1_stall_miss", bus.stall, 1);
        check("s1_no_re_idle", bus.rom_re, 0);
        tick();
        check("s1_rom_re", bus.rom_re, 1);
        check("s1_rom_addr", bus.rom_addr, 32'h0);
        check("s1_miss_cnt", bus.miss_cnt, 1);
        serve(3, LINE_A);
        check("s1_fill_re", bus.rom_re, 0);
        check("s1_fill_stall", bus.stall, 1);
        tick();
        check("s1_inst", bus.inst, 32'h11);
        check("s1_inst_valid", bus.inst_valid, 1);
        check("s1_stall0", bus.stall, 0);

        // Scenario 2: back-to-back hits in the same line
        tick(); bus.fetch_addr = 32'h4; #1;
        check("s2_inst4", bus.inst, 32'h22);
        check("s2_stall4", bus.stall, 0);
        tick(); bus.fetch_addr = 32'h8; #1;
        check("s2_inst8", bus.inst, 32'h33);
        tick(); bus.fetch_addr = 32'hC; #1;
        check("s2_instC", bus.inst, 32'h44);
        check("s2_stallC", bus.stall, 0);
        tick(); bus.fetch_req = 1'b0; #1;
        check("s2_hit_cnt", bus.hit_cnt, 4);

        // Scenario 3: conflict miss on index 0, then the evicted line misses again
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h100; #1;
        check("s3_stall", bus.stall, 1);
        serve(2, LINE_B);
        check("s3_rom_addr", bus.rom_addr, 32'h100);
        tick();
        check("s3_inst", bus.inst, 32'hB0);
        bus.fetch_addr = 32'h0; #1;
        check("s3_evicted_stall", bus.stall, 1);
        serve(1, LINE_A);
        check("s3_miss_cnt", bus.miss_cnt, 3);
        tick();
        check("s3_inst0", bus.inst, 32'h11);

        // Scenario 4: flush during REQ leaves the refilled line invalid
        bus.fetch_addr = 32'h200;
        tick();
        check("s4_rom_re", bus.rom_re, 1);
        check("s4_rom_addr", bus.rom_addr, 32'h200);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        bus.rom_out = LINE_C; bus.rom_oe = 1'b1;
        tick();
        bus.rom_oe = 1'b0;
        check("s4_fill_re", bus.rom_re, 0);
        tick();
        check("s4_retry_stall", bus.stall, 1);
        check("s4_retry_iv", bus.inst_valid, 0);
        tick();
        check("s4_retry_re", bus.rom_re, 1);
        check("s4_retry_addr", bus.rom_addr, 32'h200);
        check("s4_miss_cnt", bus.miss_cnt, 5);
        serve(2, LINE_C);
        tick();
        check("s4_inst", bus.inst, 32'hC0);

        // Scenario 5: asynchronous reset mid-refill
        bus.fetch_addr = 32'h300;
        tick();
        check("s5_rom_re", bus.rom_re, 1);
        #2 reset = 1'b1;
        #1;
        check("s5_async_re", bus.rom_re, 0);
        check("s5_async_addr", bus.rom_addr, 32'h0);
        tick();
        bus.fetch_req = 1'b0;
        reset = 1'b0;
        bus.rom_out = LINE_D; bus.rom_oe = 1'b1;
        tick();
        bus.rom_oe = 1'b0;
        check("s5_stray_oe_re", bus.rom_re, 0);
        check("s5_miss_cnt0", bus.miss_cnt, 0);
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0; #1;
        check("s5_stall", bus.stall, 1);
        tick();
        check("s5_rom_re_again", bus.rom_re, 1);
        check("s5_rom_addr_again", bus.rom_addr, 32'h0);
        serve(2, LINE_A);
        tick();

        // Scenario 6: hit counter saturation
        for (int i = 0; i < 20; i++) begin
            bus.fetch_addr = (i % 2 == 0) ? 32'h0 : 32'h4;
            tick();
        end
        bus.fetch_req = 1'b0; #1;
        check("s6_hit_sat", bus.hit_cnt, 32'hF);
        check("s6_miss_cnt", bus.miss_cnt, 1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
